chacha_round_ctrl: RTL and testbench

CHACHA_ROUND_CTRL -- requirements
Module: chacha_round_ctrl

---
 rtl/chacha_round_ctrl.sv | 140 ++++++++++++++
 tb/tb_chacha_round_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_round_ctrl.sv
// Iterative ChaCha core: one quarter-round per cycle on a 16x32 working state.
// Define CHACHA_FINALIZE_EN to add the original state in FINAL (block function); otherwise the raw permutation is output.
module chacha_round_ctrl #(
   parameter int unsigned DEFAULT_DR = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         init,
   input  logic [4:0]   rounds,
   input  logic [511:0] state_in,
   output logic         ready,
   output logic [511:0] state_out,
   output logic         valid
);

   // state | meaning
   // IDLE  | waiting for init, last result (if any) held on state_out
   // ROUND | one quarter-round applied per cycle
   // FINAL | register result, raise valid, back to IDLE
   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   state_t      st, st_nxt;
   logic [31:0] w [16];
`ifdef CHACHA_FINALIZE_EN
   logic [31:0] orig [16];
`endif
   logic [2:0]  qr_ctr;
   logic [3:0]  dr_ctr;
   logic [3:0]  dr;
   logic [3:0]  dr_req;
   logic [3:0]  ia, ib, ic, id;
   logic [31:0] qa, qb, qc, qd;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // rounds is an even round count; the shift drops bit 0
   assign dr_req = 4'(rounds >> 1);

   always_comb begin
      ia = 4'd0; ib = 4'd4; ic = 4'd8; id = 4'd12;
      case (qr_ctr)
         3'd0: begin ia = 4'd0; ib = 4'd4; ic = 4'd8;  id = 4'd12; end
         3'd1: begin ia = 4'd1; ib = 4'd5; ic = 4'd9;  id = 4'd13; end
         3'd2: begin ia = 4'd2; ib = 4'd6; ic = 4'd10; id = 4'd14; end
         3'd3: begin ia = 4'd3; ib = 4'd7; ic = 4'd11; id = 4'd15; end
         3'd4: begin ia = 4'd0; ib = 4'd5; ic = 4'd10; id = 4'd15; end
         3'd5: begin ia = 4'd1; ib = 4'd6; ic = 4'd11; id = 4'd12; end
         3'd6: begin ia = 4'd2; ib = 4'd7; ic = 4'd8;  id = 4'd13; end
         3'd7: begin ia = 4'd3; ib = 4'd4; ic = 4'd9;  id = 4'd14; end
         default: ;
      endcase
   end

   always_comb begin
      qa = w[ia];
      qb = w[ib];
      qc = w[ic];
      qd = w[id];
      qa = qa + qb; qd = rotl(qd ^ qa, 16);
      qc = qc + qd; qb = rotl(qb ^ qc, 12);
      qa = qa + qb; qd = rotl(qd ^ qa, 8);
      qc = qc + qd; qb = rotl(qb ^ qc, 7);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) st <= IDLE;
      else          st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (init) st_nxt = ROUND;
         ROUND:   if (qr_ctr == 3'd7 && dr_ctr == dr - 4'd1) st_nxt = FINAL;
         FINAL:   st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = (st == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) begin
            w[i] <= '0;
`ifdef CHACHA_FINALIZE_EN
            orig[i] <= '0;
`endif
         end
         qr_ctr    <= '0;
         dr_ctr    <= '0;
         dr        <= '0;
         valid     <= 1'b0;
         state_out <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (init) begin
                  for (int i = 0; i < 16; i++) begin
                     w[i] <= state_in[511-32*i -: 32];
`ifdef CHACHA_FINALIZE_EN
                     orig[i] <= state_in[511-32*i -: 32];
`endif
                  end
                  dr     <= (dr_req == 4'd0) ? 4'(DEFAULT_DR) : dr_req;
                  qr_ctr <= '0;
                  dr_ctr <= '0;
                  valid  <= 1'b0;
               end
            end
            ROUND: begin
               for (int i = 0; i < 16; i++) begin
                  if      (4'(i) == ia) w[i] <= qa;
                  else if (4'(i) == ib) w[i] <= qb;
                  else if (4'(i) == ic) w[i] <= qc;
                  else if (4'(i) == id) w[i] <= qd;
               end
               qr_ctr <= qr_ctr + 3'd1;
               if (qr_ctr == 3'd7) dr_ctr <= dr_ctr + 4'd1;
            end
            FINAL: begin
               for (int i = 0; i < 16; i++) begin
`ifdef CHACHA_FINALIZE_EN
                  state_out[511-32*i -: 32] <= w[i] + orig[i];
`else
                  state_out[511-32*i -: 32] <= w[i];
`endif
               end
               valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chacha_round_ctrl.sv
// Randomized self-checking bench for chacha_round_ctrl against a whole-block ChaCha reference model.
// Latency is counted inclusive of the init cycle: valid seen after edge 8*dr+1 from the sampling edge = 8*dr+2 cycles.
module tb_chacha_round_ctrl;
   localparam int DEFAULT_DR = 10;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         init = 1'b0;
   logic [4:0]   rounds = '0;
   logic [511:0] state_in = '0;
   logic         ready;
   logic [511:0] state_out;
   logic         valid;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   chacha_round_ctrl #(.DEFAULT_DR(DEFAULT_DR)) dut (
      .clk(clk), .reset_n(reset_n), .init(init), .rounds(rounds),
      .state_in(state_in), .ready(ready), .state_out(state_out), .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Reference: full ChaCha column/diagonal double rounds, optional feed-forward add
   function automatic logic [511:0] chacha_ref(input logic [511:0] s, input int ndr);
      logic [31:0] x [16];
      logic [31:0] o [16];
      logic [511:0] r;
      int q [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                       '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
      for (int i = 0; i < 16; i++) begin
         x[i] = s[511-32*i -: 32];
         o[i] = x[i];
      end
      for (int d = 0; d < ndr; d++) begin
         for (int k = 0; k < 8; k++) begin
            x[q[k][0]] += x[q[k][1]]; x[q[k][3]] = rotl(x[q[k][3]] ^ x[q[k][0]], 16);
            x[q[k][2]] += x[q[k][3]]; x[q[k][1]] = rotl(x[q[k][1]] ^ x[q[k][2]], 12);
            x[q[k][0]] += x[q[k][1]]; x[q[k][3]] = rotl(x[q[k][3]] ^ x[q[k][0]], 8);
            x[q[k][2]] += x[q[k][3]]; x[q[k][1]] = rotl(x[q[k][1]] ^ x[q[k][2]], 7);
         end
      end
      for (int i = 0; i < 16; i++) begin
`ifdef CHACHA_FINALIZE_EN
         r[511-32*i -: 32] = x[i] + o[i];
`else
         r[511-32*i -: 32] = x[i];
`endif
      end
      return r;
   endfunction

   // Cycle-level model: busy counts edges until the result appears
   int           busy = 0;
   logic         exp_valid = 1'b0;
   logic [511:0] exp_out = '0;
   logic [511:0] pend = '0;

   initial begin
      int ndr;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            busy = 0; exp_valid = 1'b0; exp_out = '0;
         end else if (busy == 0) begin
            if (init) begin
               ndr = (rounds[4:1] == 4'd0) ? DEFAULT_DR : int'(rounds[4:1]);
               pend = chacha_ref(state_in, ndr);
               busy = 8 * ndr + 1;
               exp_valid = 1'b0;
            end
         end else begin
            busy--;
            if (busy == 0) begin
               exp_valid = 1'b1;
               exp_out = pend;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("ready", ready, busy == 0);
            chk("valid", valid, exp_valid);
            chk("state_out", state_out, exp_out);
         end
      end
   end

   task automatic run_op(input logic [511:0] st, input logic [4:0] r, input int exp_lat,
                         input bit pulses, input int rst_at, input bit b2b,
                         output logic [511:0] res);
      int lat = 0;
      bit aborted = 1'b0;
      if (!b2b) begin @(posedge clk); #1; end
      state_in = st; rounds = r; init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      if (b2b) chk("b2b_valid_drop", valid, 1'b0);
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         if (valid) begin
            init = 1'b0;
            lat = n + 1;
            break;
         end
         if (rst_at == n) begin
            reset_n = 1'b0;
            #1;
            chk("rst_ready", ready, 1'b1);
            chk("rst_valid", valid, 1'b0);
            chk("rst_state_out", state_out, '0);
            @(negedge clk);
            reset_n = 1'b1;
            aborted = 1'b1;
            break;
         end
         init = pulses && (n == 4 || n == exp_lat - 2);
      end
      init = 1'b0;
      if (!aborted) begin
         if (lat == 0) begin
            checks++; failures++;
            $display("FAIL timeout actual=no_valid required=latency_%0d", exp_lat);
         end else begin
            chk("latency", lat, exp_lat);
         end
      end
      res = state_out;
   endtask

   function automatic logic [511:0] rand_state();
      logic [511:0] s;
      for (int i = 0; i < 16; i++) s[511-32*i -: 32] = $urandom;
      return s;
   endfunction

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [511:0] rfc;
      logic [511:0] res;
      logic [31:0]  exp_w0;
      logic [4:0]   r;
      int           d;
`ifdef CHACHA_FINALIZE_EN
      exp_w0 = 32'he4e7f110;
`else
      exp_w0 = 32'h837778ab;
`endif
      rfc = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
             32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
             32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
             32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", ready, 1'b1);
      chk("reset_valid", valid, 1'b0);
      chk("reset_state_out", state_out, '0);
      reset_n = 1'b1;
      cmp_en = 1'b1;

      // model pinned by the RFC vector
      res = chacha_ref(rfc, 10);
      chk("model_rfc_w0", res[511:480], exp_w0);
      chk("model_rfc_w15", res[31:0], 32'h4e3c50a2);

      run_op(rfc, 5'd20, 82, 1'b0, 0, 1'b0, res);
      chk("rfc_w0", res[511:480], exp_w0);
      chk("rfc_w15", res[31:0], 32'h4e3c50a2);

      run_op(rand_state(), 5'd8, 34, 1'b0, 0, 1'b0, res);
      run_op(rand_state(), 5'd12, 50, 1'b0, 0, 1'b0, res);
      run_op(rand_state(), 5'd0, 82, 1'b0, 0, 1'b0, res);

      run_op(rfc, 5'd20, 82, 1'b1, 0, 1'b0, res);
      chk("pulsed_rfc_w0", res[511:480], exp_w0);

      run_op(rand_state(), 5'd20, 82, 1'b0, 40, 1'b0, res);
      run_op(rfc, 5'd20, 82, 1'b0, 0, 1'b0, res);
      chk("post_reset_rfc_w0", res[511:480], exp_w0);

      run_op(rand_state(), 5'd21, 82, 1'b0, 0, 1'b1, res);
      run_op(rfc, 5'd20, 82, 1'b0, 0, 1'b1, res);
      chk("b2b_rfc_w15", res[31:0], 32'h4e3c50a2);

      for (int k = 0; k < 6; k++) begin
         r = 5'($urandom_range(0, 31));
         d = (r[4:1] == 4'd0) ? DEFAULT_DR : int'(r[4:1]);
         run_op(rand_state(), r, 8 * d + 2, k[0], 0, k == 3, res);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
